ibex_rf_spill_fill: RTL
=======================

Name: ibex_rf_spill_fill

Overview:
Context save/restore engine for the register-file cache. It streams architectural registers x1..xN out to memory (spill) or back in from memory (fill). This runs while the core is stalled on a register-file switch.
It sits between the register-file write/read ports on one side and an Ibex-style data-bus initiator on the other. It is the memory-facing counterpart of the register-file cache: it reads the file on spill and writes it on fill.

Parameters:
RV32E, 0, 1: transfer x1..x15 (15 regs); 0: transfer x1..x31 (31 regs)
DataWidth, 32, register/bus word width; only 32 supported

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  command strobe; sampled only in IDLE
op_fill_i  in  1  0 = spill (RF->mem), 1 = fill (mem->RF); latched with start_i
base_addr_i  in  32  save-area base; latched with start_i, bits [1:0] forced to 0
busy_o  out  1  high from the cycle after an accepted start until done; core stalls RF use while high
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: transfer aborted on bus error
rf_raddr_o  out  5  RF read address (spill)
rf_rdata_i  in  32  RF read data, combinational from rf_raddr_o
rf_waddr_o  out  5  RF write address (fill)
rf_wdata_o  out  32  RF write data
rf_we_o  out  1  RF write enable, one-cycle pulse per register
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  bus response valid
data_err_i  in  1  bus error, valid with rvalid
data_we_o  out  1  1 = store (spill)
data_be_o  out  4  always 4'b1111
data_addr_o  out  32  base + {idx, 2'b00}; the x0 slot is reserved and never accessed
data_wdata_o  out  32  equals rf_rdata_i
data_rdata_i  in  32  load data

Behaviour:
- Reset (async, any state): state=IDLE, idx=1.
  - Outputs: busy_o, done_o, err_o, data_req_o, rf_we_o = 0.
  - rf_raddr_o, rf_waddr_o, data_addr_o, data_wdata_o, rf_wdata_o = 0.
  - An in-flight transfer is abandoned. No done_o pulse follows reset.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on start_i=1, latch op, base and idx=1, then go to REQ. In any other state start_i is ignored.
- REQ:
  - data_req_o=1.
  - addr/we/wdata are held stable until the grant.
  - rf_raddr_o=idx during REQ and WAIT.
  - On data_gnt_i go to WAIT; data_req_o drops the next cycle.
  - Only one transaction is outstanding at a time.
- WAIT, on data_rvalid_i:
  - If data_err_i: set err flag and go to DONE. For fill, no RF write occurs.
  - Else if fill: rf_we_o=1 in this same cycle, with rf_waddr_o=idx and rf_wdata_o=data_rdata_i.
  - Then, if idx==last (31, or 15 when RV32E), go to DONE; else idx++ and go to REQ.
- DONE: done_o=1 and err_o=err flag for exactly one cycle, then go to IDLE.
  - busy_o=0 in IDLE only.
  - err flag clears on the next accepted start.
- rvalid outside WAIT, and gnt outside REQ, are ignored.
- Address arithmetic is 32-bit modulo, so a base near 0xFFFF_FFFC wraps.
- Latency with gnt held at 1 and rvalid one cycle after gnt:
  - start sampled at edge 0; register k requests in cycle 2k-1 and responds in cycle 2k.
  - done_o is high in cycle 2N+1 (N = register count).
  - This gives 63 cycles for N=31 and 31 cycles for N=15.
- Spill never writes the RF; fill never drives data_we_o.

Test Plan:
1. Spill, RF xi=0xA500_0000+i, base=0x1000, gnt=1, rvalid at +1 -> 31 stores at 0x1004..0x107C with data 0xA500_0001..0xA500_001F; done_o in cycle 63; err_o=0; no rf_we_o.
2. Fill, memory word at 0x2000+4i = ~i, base=0x2000 -> rf_we_o 31 times, rf_waddr_o 1..31, data ~i; done_o in cycle 63.
3. RV32E=1 spill with random gnt delay 0-3 cycles -> exactly 15 requests; address/we/wdata stable while req=1 && gnt=0; done_o once at the end.
4. Fill with data_err_i on the 5th response (x5) -> rf_we_o only for x1..x4; done_o=1 with err_o=1; no further requests; next start clears err_o.
5. start_i pulsed while busy, plus stray rvalid while in REQ -> ignored; transfer count and addresses unchanged.
6. rst_i asserted asynchronously mid-spill at idx=10 -> busy_o and data_req_o drop immediately, no done_o; a new start re-begins at x1.

Source files
------------

// File: rtl/ibex_rf_spill_fill.sv
// -----------------------------------------------------------------------------
// ibex_rf_spill_fill
// -----------------------------------------------------------------------------
// Context save/restore engine for the register-file cache. One command moves
// architectural registers x1..xLast between the register file and a save area
// in memory. The core is stalled on the register-file switch while this runs.
//   spill : RF -> memory, one store per register
//   fill  : memory -> RF, one load per register and one RF write per load
// Register xi lives at base + 4*i. The x0 slot is reserved and never touched.
// Only one bus transaction is outstanding at a time.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             command strobe, sampled only while idle
//   op_fill_i           0 = spill, 1 = fill (latched with start_i)
//   base_addr_i         save-area base (latched with start_i, word aligned)
//   busy_o              high in every state except idle
//   done_o / err_o      one-cycle completion pulse / aborted on bus error
//   rf_raddr_o          RF read address (spill), rf_rdata_i comes back combinationally
//   rf_waddr_o, rf_wdata_o, rf_we_o
//                       RF write port (fill), one pulse per register
//   data_*              Ibex-style data-bus initiator (req/gnt/rvalid/err)
// -----------------------------------------------------------------------------
module ibex_rf_spill_fill #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 op_fill_i,
    input  logic [31:0]          base_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [4:0]           rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic                 data_err_i,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [31:0]          data_addr_o,
    output logic [DataWidth-1:0] data_wdata_o,
    input  logic [DataWidth-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Highest register moved by one command.
    localparam logic [4:0] LastIdx = RV32E ? 5'd15 : 5'd31;

    // Save-area slot address for register idx; plain 32-bit modulo arithmetic,
    // so a base near the top of the address space wraps through zero.
    function automatic logic [31:0] slot_addr(input logic [31:0] base,
                                              input logic [4:0]  idx);
        slot_addr = base + {25'd0, idx, 2'b00};
    endfunction

    // Bits [1:0] of the base are dropped so every slot is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        align_word = addr & 32'hFFFF_FFFC;
    endfunction

    state_e      state_r;
    state_e      state_s;
    logic [4:0]  idx_r;
    logic [4:0]  idx_s;
    logic        op_fill_r;
    logic        op_fill_s;
    logic [31:0] base_r;
    logic [31:0] base_s;
    logic        err_r;
    logic        err_s;

    logic        xfer_s;      // a register transfer is in progress (REQ or WAIT)
    logic        rsp_ok_s;    // error-free response accepted in WAIT
    logic        fill_we_s;   // this response is written into the RF

    // Command, index and state registers; reset abandons any transfer silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= S_IDLE;
            idx_r     <= 5'd1;
            op_fill_r <= 1'b0;
            base_r    <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            op_fill_r <= op_fill_s;
            base_r    <= base_s;
            err_r     <= err_s;
        end
    end

    // Next-state logic: one request, one response, then advance or finish.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        op_fill_s = op_fill_r;
        base_s    = base_r;
        err_s     = err_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    state_s   = S_REQ;
                    idx_s     = 5'd1;
                    op_fill_s = op_fill_i;
                    base_s    = align_word(base_addr_i);
                    err_s     = 1'b0;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_REQ: begin
                // A response arriving here belongs to no request of ours.
                if (data_gnt_i) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        err_s   = 1'b1;
                        state_s = S_DONE;
                    end else if (idx_r == LastIdx) begin
                        state_s = S_DONE;
                    end else begin
                        idx_s   = idx_r + 5'd1;
                        state_s = S_REQ;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode. Everything is derived from the registered state so that
    // reset forces all outputs to zero at once; the RF write is the only
    // output that follows the bus response within the same cycle.
    always_comb begin
        xfer_s    = (state_r == S_REQ) || (state_r == S_WAIT);
        rsp_ok_s  = (state_r == S_WAIT) && data_rvalid_i && !data_err_i;
        fill_we_s = rsp_ok_s && op_fill_r;

        busy_o       = (state_r != S_IDLE);
        done_o       = (state_r == S_DONE);
        err_o        = (state_r == S_DONE) && err_r;

        data_req_o   = (state_r == S_REQ);
        data_be_o    = 4'b1111;

        if (xfer_s) begin
            data_addr_o = slot_addr(base_r, idx_r);
            rf_raddr_o  = idx_r;
        end else begin
            data_addr_o = 32'd0;
            rf_raddr_o  = 5'd0;
        end

        // Store data and we are only driven for spills; a fill is a pure load.
        if (xfer_s && !op_fill_r) begin
            data_we_o    = 1'b1;
            data_wdata_o = rf_rdata_i;
        end else begin
            data_we_o    = 1'b0;
            data_wdata_o = {DataWidth{1'b0}};
        end

        // A failed load never reaches the register file.
        if (fill_we_s) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = idx_r;
            rf_wdata_o = data_rdata_i;
        end else begin
            rf_we_o    = 1'b0;
            rf_waddr_o = 5'd0;
            rf_wdata_o = {DataWidth{1'b0}};
        end
    end

endmodule
